vic_wb_buffer: RTL and testbench

VIC_WB_BUFFER -- requirements
Module: vic_wb_buffer

---
 rtl/vic_wb_buffer.sv | 159 +++++++++++++++
 tb/tb_vic_wb_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_wb_buffer.sv
// Victim write-back buffer: queues evicted lines, drains them to memory
// as BUS_STOREs and forwards queued data to miss-path lookups.
`ifndef NUM_SET_BITS
`define NUM_SET_BITS 5
`endif
`ifndef NUM_TAG_BITS
`define NUM_TAG_BITS 16
`endif

package vic_wb_pkg;
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef struct packed {
    logic [`NUM_TAG_BITS-1:0] tag;
    logic [63:0]              data;
  } CACHE_LINE_T;
endpackage

module vic_wb_buffer
  import vic_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      fired_valid1,
  input  logic                      fired_valid2,
  input  CACHE_LINE_T               fired_victim1,
  input  CACHE_LINE_T               fired_victim2,
  input  logic [`NUM_SET_BITS-1:0]  fired_set1,
  input  logic [`NUM_SET_BITS-1:0]  fired_set2,
  input  logic                      bus_grant,
  input  logic [3:0]                mem2proc_response,
  input  logic                      lookup_valid,
  input  logic [`NUM_TAG_BITS-1:0]  lookup_tag,
  input  logic [`NUM_SET_BITS-1:0]  lookup_set,
  output logic [1:0]                proc2mem_command,
  output logic [63:0]               proc2mem_addr,
  output logic [63:0]               proc2mem_data,
  output logic                      lookup_hit,
  output logic [63:0]               lookup_data,
  output logic [$clog2(DEPTH):0]    wb_count,
  output logic                      wb_full,
  output logic                      wb_empty,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = `NUM_TAG_BITS;
  localparam int SW = `NUM_SET_BITS;
  localparam int PADW = 64 - TW - SW - 3;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tag_q  [DEPTH];
  logic [SW-1:0]   set_q  [DEPTH];
  logic [63:0]     data_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   slot2, idx;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   free;
  logic            ovf_q, ovf_d;
  logic            pop, acc1, acc2;
  logic            issuing;

  // Free space counts the slot released by a same-cycle pop.
  always_comb begin
    pop     = (state_q == ISSUE) && (mem2proc_response != 4'h0)
              && (count_q != '0);
    free    = CW'(DEPTH) - count_q + CW'(pop);
    acc1    = fired_valid1 && (free != '0);
    acc2    = fired_valid2 && (free > CW'(acc1));
    slot2   = tail_q + PW'(acc1);
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(acc1) + PW'(acc2);
    count_d = count_q + CW'(acc1) + CW'(acc2) - CW'(pop);
    ovf_d   = ovf_q | (fired_valid1 & ~acc1) | (fired_valid2 & ~acc2);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && bus_grant) state_d = ISSUE;
      end
      ISSUE: begin
        if (pop) begin
          state_d = ((count_d != '0) && bus_grant) ? ISSUE : IDLE;
        end else if (!bus_grant) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issuing          = (state_q == ISSUE);
  assign proc2mem_command = issuing ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = issuing ?
    {{PADW{1'b0}}, tag_q[head_q], set_q[head_q], 3'b000} : '0;
  assign proc2mem_data    = issuing ? data_q[head_q] : '0;

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (lookup_valid && (CW'(i) < count_q) &&
          (tag_q[idx] == lookup_tag) && (set_q[idx] == lookup_set)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        set_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (acc1) begin
        tag_q[tail_q]  <= fired_victim1.tag;
        set_q[tail_q]  <= fired_set1;
        data_q[tail_q] <= fired_victim1.data;
      end
      if (acc2) begin
        tag_q[slot2]  <= fired_victim2.tag;
        set_q[slot2]  <= fired_set2;
        data_q[slot2] <= fired_victim2.data;
      end
    end
  end

  assign wb_count = count_q;
  assign wb_full  = count_q > CW'(DEPTH - 2);
  assign wb_empty = (count_q == '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_vic_wb_buffer.sv
// Directed bench for vic_wb_buffer (DEPTH=4): enqueue, drain,
// overflow, forwarding and reset behaviour.
`ifndef NUM_SET_BITS
`define NUM_SET_BITS 5
`endif
`ifndef NUM_TAG_BITS
`define NUM_TAG_BITS 16
`endif

module tb_vic_wb_buffer;
  import vic_wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fired_valid1 = 1'b0;
  logic        fired_valid2 = 1'b0;
  CACHE_LINE_T fired_victim1 = '0;
  CACHE_LINE_T fired_victim2 = '0;
  logic [`NUM_SET_BITS-1:0] fired_set1 = '0;
  logic [`NUM_SET_BITS-1:0] fired_set2 = '0;
  logic        bus_grant = 1'b0;
  logic [3:0]  mem2proc_response = 4'h0;
  logic        lookup_valid = 1'b0;
  logic [`NUM_TAG_BITS-1:0] lookup_tag = '0;
  logic [`NUM_SET_BITS-1:0] lookup_set = '0;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic        lookup_hit;
  logic [63:0] lookup_data;
  logic [2:0]  wb_count;
  logic        wb_full;
  logic        wb_empty;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  vic_wb_buffer #(.DEPTH(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .fired_valid1      (fired_valid1),
    .fired_valid2      (fired_valid2),
    .fired_victim1     (fired_victim1),
    .fired_victim2     (fired_victim2),
    .fired_set1        (fired_set1),
    .fired_set2        (fired_set2),
    .bus_grant         (bus_grant),
    .mem2proc_response (mem2proc_response),
    .lookup_valid      (lookup_valid),
    .lookup_tag        (lookup_tag),
    .lookup_set        (lookup_set),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .lookup_hit        (lookup_hit),
    .lookup_data       (lookup_data),
    .wb_count          (wb_count),
    .wb_full           (wb_full),
    .wb_empty          (wb_empty),
    .overflow          (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_v1(input logic [15:0] t, input logic [4:0] s,
                        input logic [63:0] d);
    fired_victim1.tag  = t;
    fired_victim1.data = d;
    fired_set1         = s;
  endtask

  task automatic set_v2(input logic [15:0] t, input logic [4:0] s,
                        input logic [63:0] d);
    fired_victim2.tag  = t;
    fired_victim2.data = d;
    fired_set2         = s;
  endtask

  task automatic push1(input logic [15:0] t, input logic [4:0] s,
                       input logic [63:0] d);
    set_v1(t, s, d);
    fired_valid1 = 1'b1;
    tick();
    fired_valid1 = 1'b0;
  endtask

  task automatic push2(input logic [15:0] ta, input logic [15:0] tb,
                       input logic [63:0] da, input logic [63:0] db);
    set_v1(ta, 5'd0, da);
    set_v2(tb, 5'd0, db);
    fired_valid1 = 1'b1;
    fired_valid2 = 1'b1;
    tick();
    fired_valid1 = 1'b0;
    fired_valid2 = 1'b0;
  endtask

  task automatic probe(input logic [15:0] t, input logic [4:0] s);
    lookup_valid = 1'b1;
    lookup_tag   = t;
    lookup_set   = s;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    push2(16'h77, 16'h78, 64'h1, 64'h2);
    tick();
    reset = 1'b1;
    n_cmp++; if (wb_count !== 3'd0) begin n_fail++;
      $display("FAIL rst_count got %0d exp 0", wb_count); end
    n_cmp++; if (wb_empty !== 1'b1) begin n_fail++;
      $display("FAIL rst_empty got %b exp 1", wb_empty); end
    n_cmp++; if (wb_full !== 1'b0) begin n_fail++;
      $display("FAIL rst_full got %b exp 0", wb_full); end
    n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++;
      $display("FAIL rst_cmd got %0d exp 0", proc2mem_command); end
    n_cmp++; if (proc2mem_addr !== 64'h0) begin n_fail++;
      $display("FAIL rst_addr got %h exp 0", proc2mem_addr); end
    n_cmp++; if (proc2mem_data !== 64'h0) begin n_fail++;
      $display("FAIL rst_data got %h exp 0", proc2mem_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++;
      $display("FAIL rst_ovf got %b exp 0", overflow); end
    probe(16'h77, 5'd0);
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++;
      $display("FAIL rst_hit got %b exp 0", lookup_hit); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_single;
    bus_grant = 1'b0;
    mem2proc_response = 4'h0;
    push1(16'h12, 5'd3, 64'hAA);
    n_cmp++; if (wb_count !== 3'd1) begin n_fail++;
      $display("FAIL single_count got %0d exp 1", wb_count); end
    n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++;
      $display("FAIL single_idle got %0d exp 0", proc2mem_command); end
    bus_grant = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (proc2mem_command !== BUS_STORE) begin n_fail++;
        $display("FAIL single_cmd%0d got %0d exp 2", k, proc2mem_command); end
      n_cmp++; if (proc2mem_addr !== 64'h1218) begin n_fail++;
        $display("FAIL single_addr%0d got %h exp 1218", k, proc2mem_addr); end
      n_cmp++; if (proc2mem_data !== 64'hAA) begin n_fail++;
        $display("FAIL single_data%0d got %h exp aa", k, proc2mem_data); end
      if (k == 2) mem2proc_response = 4'h5;
      tick();
    end
    mem2proc_response = 4'h0;
    n_cmp++; if (wb_empty !== 1'b1) begin n_fail++;
      $display("FAIL single_empty got %b exp 1", wb_empty); end
    n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++;
      $display("FAIL single_done got %0d exp 0", proc2mem_command); end
    n_cmp++; if (proc2mem_addr !== 64'h0) begin n_fail++;
      $display("FAIL single_addr0 got %h exp 0", proc2mem_addr); end
    bus_grant = 1'b0;
  endtask

  task automatic test_dual;
    set_v1(16'h0A, 5'd1, 64'h111);
    set_v2(16'h0B, 5'd2, 64'h222);
    fired_valid1 = 1'b1;
    fired_valid2 = 1'b1;
    tick();
    fired_valid1 = 1'b0;
    fired_valid2 = 1'b0;
    n_cmp++; if (wb_count !== 3'd2) begin n_fail++;
      $display("FAIL dual_count got %0d exp 2", wb_count); end
    bus_grant = 1'b1;
    tick();
    n_cmp++; if (proc2mem_addr !== 64'hA08) begin n_fail++;
      $display("FAIL dual_addrA got %h exp a08", proc2mem_addr); end
    n_cmp++; if (proc2mem_data !== 64'h111) begin n_fail++;
      $display("FAIL dual_dataA got %h exp 111", proc2mem_data); end
    mem2proc_response = 4'h1;
    tick();
    n_cmp++; if (proc2mem_command !== BUS_STORE) begin n_fail++;
      $display("FAIL dual_cmdB got %0d exp 2", proc2mem_command); end
    n_cmp++; if (proc2mem_addr !== 64'hB10) begin n_fail++;
      $display("FAIL dual_addrB got %h exp b10", proc2mem_addr); end
    n_cmp++; if (proc2mem_data !== 64'h222) begin n_fail++;
      $display("FAIL dual_dataB got %h exp 222", proc2mem_data); end
    n_cmp++; if (wb_count !== 3'd1) begin n_fail++;
      $display("FAIL dual_count1 got %0d exp 1", wb_count); end
    tick();
    mem2proc_response = 4'h0;
    bus_grant = 1'b0;
    n_cmp++; if (wb_empty !== 1'b1) begin n_fail++;
      $display("FAIL dual_empty got %b exp 1", wb_empty); end
    n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++;
      $display("FAIL dual_done got %0d exp 0", proc2mem_command); end
  endtask

  task automatic test_overflow;
    do_reset();
    bus_grant = 1'b0;
    push1(16'h1, 5'd0, 64'h10);
    push1(16'h2, 5'd0, 64'h20);
    n_cmp++; if (wb_full !== 1'b0) begin n_fail++;
      $display("FAIL ovf_full2 got %b exp 0", wb_full); end
    push1(16'h3, 5'd0, 64'h30);
    n_cmp++; if (wb_full !== 1'b1) begin n_fail++;
      $display("FAIL ovf_full3 got %b exp 1", wb_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++;
      $display("FAIL ovf_pre got %b exp 0", overflow); end
    push2(16'h4, 16'h5, 64'h40, 64'h50);
    n_cmp++; if (wb_count !== 3'd4) begin n_fail++;
      $display("FAIL ovf_count got %0d exp 4", wb_count); end
    n_cmp++; if (wb_full !== 1'b1) begin n_fail++;
      $display("FAIL ovf_full got %b exp 1", wb_full); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++;
      $display("FAIL ovf_flag got %b exp 1", overflow); end
    probe(16'h4, 5'd0);
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h40) begin
      n_fail++;
      $display("FAIL ovf_v1 got %b/%h exp 1/40", lookup_hit, lookup_data); end
    probe(16'h5, 5'd0);
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++;
      $display("FAIL ovf_v2drop got %b exp 0", lookup_hit); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_pop_enq;
    do_reset();
    push2(16'h1, 16'h2, 64'h10, 64'h20);
    push2(16'h3, 16'h4, 64'h30, 64'h40);
    n_cmp++; if (wb_count !== 3'd4 || overflow !== 1'b0) begin n_fail++;
      $display("FAIL pe_fill got %0d/%b exp 4/0", wb_count, overflow); end
    bus_grant = 1'b1;
    tick();
    n_cmp++; if (proc2mem_addr !== 64'h100) begin n_fail++;
      $display("FAIL pe_head got %h exp 100", proc2mem_addr); end
    mem2proc_response = 4'h1;
    set_v1(16'h6, 5'd0, 64'h60);
    set_v2(16'h7, 5'd0, 64'h70);
    fired_valid1 = 1'b1;
    fired_valid2 = 1'b1;
    tick();
    fired_valid1 = 1'b0;
    fired_valid2 = 1'b0;
    mem2proc_response = 4'h0;
    n_cmp++; if (wb_count !== 3'd4) begin n_fail++;
      $display("FAIL pe_count got %0d exp 4", wb_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++;
      $display("FAIL pe_ovf got %b exp 1", overflow); end
    n_cmp++; if (proc2mem_addr !== 64'h200) begin n_fail++;
      $display("FAIL pe_next got %h exp 200", proc2mem_addr); end
    probe(16'h6, 5'd0);
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h60) begin
      n_fail++;
      $display("FAIL pe_v1 got %b/%h exp 1/60", lookup_hit, lookup_data); end
    probe(16'h7, 5'd0);
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++;
      $display("FAIL pe_v2drop got %b exp 0", lookup_hit); end
    probe(16'h1, 5'd0);
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++;
      $display("FAIL pe_popped got %b exp 0", lookup_hit); end
    lookup_valid = 1'b0;
    bus_grant = 1'b0;
    tick();
    n_cmp++; if (proc2mem_command !== BUS_NONE || wb_count !== 3'd4) begin
      n_fail++;
      $display("FAIL pe_revoke got %0d/%0d exp 0/4",
               proc2mem_command, wb_count); end
  endtask

  task automatic test_forward;
    do_reset();
    push1(16'h44, 5'd6, 64'h99);
    push1(16'h33, 5'd5, 64'h1);
    push1(16'h33, 5'd5, 64'h2);
    probe(16'h33, 5'd5);
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h2) begin
      n_fail++;
      $display("FAIL fw_young got %b/%h exp 1/2", lookup_hit, lookup_data); end
    probe(16'h33, 5'd4);
    n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 64'h0) begin
      n_fail++;
      $display("FAIL fw_miss got %b/%h exp 0/0", lookup_hit, lookup_data); end
    set_v1(16'h55, 5'd7, 64'h5555);
    fired_valid1 = 1'b1;
    probe(16'h55, 5'd7);
    n_cmp++; if (lookup_hit !== 1'b0) begin n_fail++;
      $display("FAIL fw_sameenq got %b exp 0", lookup_hit); end
    tick();
    fired_valid1 = 1'b0;
    #1;
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h5555) begin
      n_fail++;
      $display("FAIL fw_enq got %b/%h exp 1/5555", lookup_hit, lookup_data); end
    bus_grant = 1'b1;
    tick();
    mem2proc_response = 4'h1;
    probe(16'h44, 5'd6);
    n_cmp++; if (lookup_hit !== 1'b1 || lookup_data !== 64'h99) begin
      n_fail++;
      $display("FAIL fw_pophead got %b/%h exp 1/99", lookup_hit, lookup_data); end
    tick();
    mem2proc_response = 4'h0;
    bus_grant = 1'b0;
    #1;
    n_cmp++; if (lookup_hit !== 1'b0 || wb_count !== 3'd3) begin n_fail++;
      $display("FAIL fw_gone got %b/%0d exp 0/3", lookup_hit, wb_count); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_reset_issue;
    do_reset();
    push2(16'h8, 16'h9, 64'h80, 64'h90);
    bus_grant = 1'b1;
    tick();
    n_cmp++; if (proc2mem_command !== BUS_STORE || wb_count !== 3'd2) begin
      n_fail++;
      $display("FAIL ri_pre got %0d/%0d exp 2/2", proc2mem_command, wb_count); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++;
      $display("FAIL ri_cmd got %0d exp 0", proc2mem_command); end
    n_cmp++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin n_fail++;
      $display("FAIL ri_count got %0d/%b exp 0/1", wb_count, wb_empty); end
    tick();
    n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++;
      $display("FAIL ri_idle got %0d exp 0", proc2mem_command); end
    push1(16'hC, 5'd1, 64'hCC);
    tick();
    n_cmp++; if (proc2mem_addr !== 64'hC08 || proc2mem_data !== 64'hCC) begin
      n_fail++;
      $display("FAIL ri_restart got %h/%h exp c08/cc",
               proc2mem_addr, proc2mem_data); end
    bus_grant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_overflow();
    test_pop_enq();
    test_forward();
    test_reset_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
